depacketer: RTL and testbench
=============================

# depacketer

Receive-side counterpart of the flit builder. Accepts 73-bit flits from the router ejection port, checks the destination coordinates against this node's rank, buffers matching flits in a small FIFO, and presents decoded header and payload fields to the local collective engine over a valid/ready handshake. Misrouted flits are discarded and counted.

## Interface
- rank_x, 3'b000, this node's X coordinate
- rank_y, 3'b000, this node's Y coordinate
- rank_z, 3'b000, this node's Z coordinate
- FlitWidth, 73, flit width; layout fixed as below
- FifoDepth, 4, buffer entries; power of two, ≥2
- CntWidth, 16, width of the statistics counters
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flitIn  in  FlitWidth  incoming flit; bit 72 is the valid bit
- flitInReady  out  1  high when a flit presented this cycle is consumed
- outValid  out  1  decoded flit available at FIFO head
- outReady  in  1  consumer accepts head this cycle
- payload  out  32  flit[31:0]
- op  out  4  flit[35:32]
- algtype  out  2  flit[37:36]
- tag  out  8  flit[45:38]
- contextId  out  8  flit[53:46]
- src_x, src_y, src_z  out  3 each  flit[56:54], [59:57], [62:60]
- rxCount  out  CntWidth  flits delivered into the FIFO
- dropCount  out  CntWidth  misrouted flits discarded

## Operation
- Flit layout: valid 72, dst_z 71:69, dst_y 68:66, dst_x 65:63, src_z 62:60, src_y 59:57, src_x 56:54, contextId 53:46, tag 45:38, algtype 37:36, op 35:32, payload 31:0.
- flitInReady = !full. The sender holds the flit until it sees flitInReady high on a cycle with flitIn[72]=1.
- Accept event: flitIn[72] && flitInReady.
- On accept, match = (dst_x==rank_x && dst_y==rank_y && dst_z==rank_z).
  - match: push bits [71:0] into FIFO at wrPtr; wrPtr++; rxCount++.
  - no match: no push; dropCount++. A mismatched flit is consumed (not retried) even though nothing is stored.
- When full, flitInReady=0 and no flit is accepted or dropped, matching or not; dropCount does not advance.
- Pop event: outValid && outReady; rdPtr++.
- outValid = !empty. Output fields decode combinationally from the head entry; they are stable while outValid && !outReady.
- When empty, output fields drive 0 (not stale data).
- FIFO: pointers of log2(FifoDepth)+1 bits; full when MSBs differ and the low bits are equal; empty when the pointers are equal; pointers wrap modulo 2·FifoDepth.
- Simultaneous push and pop when not full and not empty: both take effect; occupancy is unchanged.
- Push and pop with exactly one entry: the head pops and the new flit becomes the head next cycle; outValid stays 1.
- Full plus pop: pop occurs and flitInReady stays 0 that cycle; there is no same-cycle pass-through. The next cycle is not full.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (rst_n low, asynchronous): wrPtr=rdPtr=0, outValid=0, all field outputs 0, flitInReady=1, rxCount=0, dropCount=0. FIFO contents are don't-care.
- Reset asserted mid-operation discards all buffered flits immediately. Outputs take their reset values without waiting for a clock edge.
- Latency: a flit accepted at edge N is visible with outValid=1 after edge N (one cycle, flitIn to outValid).
- Counters update on the same edge as the accept.
- flitInReady deasserts in the cycle after the edge that fills the FIFO.
- Throughput: one flit per cycle sustained while not full and the consumer pops every cycle.

## Test plan
- Reset: hold rst_n=0 -> outValid=0, flitInReady=1, counters 0. Deassert, then assert rst_n asynchronously mid-stream with 2 flits buffered -> outValid drops to 0 before the next edge.
- Single matching flit (rank 1,2,3; dst 1,2,3; src 4,5,6; payload 32'hDEADBEEF; op 4'h3; tag 8'h5A) -> one cycle later outValid=1 with the exact fields; rxCount=1. Pop -> outValid=0.
- Misrouted flit (dst 0,2,3) -> flit consumed, dropCount=1, outValid stays 0, rxCount unchanged.
- Fill: 5 matching flits back-to-back with outReady=0 -> first 4 accepted, flitInReady=0 after the 4th, 5th held. Raise outReady -> FIFO order preserved, 5th accepted the cycle after the first pop.
- Streaming: 20 flits with outReady=1 continuously -> one flit per cycle, in-order payloads 0..19, pointer wrap exercised, rxCount=20.
- Saturation: preload dropCount near its maximum (CntWidth=4 build), send 20 misrouted flits -> dropCount holds at 4'hF.

Source files
------------

// File: rtl/depacketer.sv
// Receive-side flit depacketer: filters flits by destination rank, buffers matches in a
// small FIFO and presents decoded header/payload fields over a valid/ready handshake.
module depacketer #(
   parameter logic [2:0]  rank_x    = 3'b000,
   parameter logic [2:0]  rank_y    = 3'b000,
   parameter logic [2:0]  rank_z    = 3'b000,
   parameter int unsigned FlitWidth = 73,
   parameter int unsigned FifoDepth = 4,
   parameter int unsigned CntWidth  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [FlitWidth-1:0] flitIn,
   output logic                 flitInReady,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [31:0]          payload,
   output logic [3:0]           op,
   output logic [1:0]           algtype,
   output logic [7:0]           tag,
   output logic [7:0]           contextId,
   output logic [2:0]           src_x,
   output logic [2:0]           src_y,
   output logic [2:0]           src_z,
   output logic [CntWidth-1:0]  rxCount,
   output logic [CntWidth-1:0]  dropCount
);

   localparam int unsigned AddrW  = $clog2(FifoDepth);
   localparam int unsigned PtrW   = AddrW + 1;
   // Destination bits always equal this node's rank once stored, so only src..payload is kept.
   localparam int unsigned EntryW = 63;

   logic [PtrW-1:0]   wr_ptr, rd_ptr;
   logic [EntryW-1:0] mem [FifoDepth];
   logic [EntryW-1:0] head;
   logic              full, empty;
   logic              dst_match, accept, push, drop, pop;

   assign full  = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                  (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign dst_match = (flitIn[65:63] == rank_x) && (flitIn[68:66] == rank_y) &&
                      (flitIn[71:69] == rank_z);
   assign accept    = flitIn[FlitWidth-1] && !full;
   assign push      = accept && dst_match;
   assign drop      = accept && !dst_match;
   assign pop       = !empty && outReady;

   // Pointer and counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rxCount   <= '0;
         dropCount <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
         if (push && (rxCount != '1))   rxCount   <= rxCount + CntWidth'(1);
         if (drop && (dropCount != '1)) dropCount <= dropCount + CntWidth'(1);
      end
   end

   // Storage needs no reset; emptiness is tracked by the pointers alone
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AddrW-1:0]] <= flitIn[EntryW-1:0];
   end

   assign head = empty ? '0 : mem[rd_ptr[AddrW-1:0]];

   assign flitInReady = !full;
   assign outValid    = !empty;
   assign payload     = head[31:0];
   assign op          = head[35:32];
   assign algtype     = head[37:36];
   assign tag         = head[45:38];
   assign contextId   = head[53:46];
   assign src_x       = head[56:54];
   assign src_y       = head[59:57];
   assign src_z       = head[62:60];

endmodule

// File: tb/tb_depacketer.sv
// Scoreboard bench for depacketer: driver pushes expected heads, monitor pops on handshake.
module tb_depacketer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [72:0] flit_in, flit_in2;
   logic        out_ready;

   logic        flit_in_ready, out_valid;
   logic [31:0] payload;
   logic [3:0]  op;
   logic [1:0]  algtype;
   logic [7:0]  tag, context_id;
   logic [2:0]  src_x, src_y, src_z;
   logic [15:0] rx_count, drop_count;

   logic        flit_in_ready2, out_valid2;
   logic [31:0] payload2;
   logic [3:0]  op2;
   logic [1:0]  algtype2;
   logic [7:0]  tag2, context_id2;
   logic [2:0]  src_x2, src_y2, src_z2;
   logic [3:0]  rx_count2, drop_count2;

   int checks = 0;
   int errors = 0;
   logic [62:0] exp_q [$];

   always #5 clk = ~clk;

   depacketer #(.rank_x(3'd1), .rank_y(3'd2), .rank_z(3'd3)) dut (
      .clk(clk), .rst_n(rst_n), .flitIn(flit_in), .flitInReady(flit_in_ready),
      .outValid(out_valid), .outReady(out_ready), .payload(payload), .op(op),
      .algtype(algtype), .tag(tag), .contextId(context_id), .src_x(src_x),
      .src_y(src_y), .src_z(src_z), .rxCount(rx_count), .dropCount(drop_count));

   depacketer #(.rank_x(3'd1), .rank_y(3'd2), .rank_z(3'd3), .CntWidth(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flitIn(flit_in2), .flitInReady(flit_in_ready2),
      .outValid(out_valid2), .outReady(1'b0), .payload(payload2), .op(op2),
      .algtype(algtype2), .tag(tag2), .contextId(context_id2), .src_x(src_x2),
      .src_y(src_y2), .src_z(src_z2), .rxCount(rx_count2), .dropCount(drop_count2));

   function automatic logic [71:0] mk(input logic [2:0] dx, dy, dz, sx, sy, sz,
                                      input logic [7:0] ctx, tg, input logic [1:0] alg,
                                      input logic [3:0] o, input logic [31:0] pl);
      return {dz, dy, dx, sz, sy, sx, ctx, tg, alg, o, pl};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Present a flit until consumed; queue its expected head fields if it should be stored
   task automatic send(input logic [71:0] f, input bit push, output int waits);
      waits = 0;
      flit_in = {1'b1, f};
      forever begin
         @(negedge clk);
         if (flit_in_ready) break;
         waits++;
         if (waits > 200) begin
            chk("send_timeout", 64'(waits), 64'd0);
            flit_in = '0;
            return;
         end
      end
      @(posedge clk);
      if (push) exp_q.push_back(f[62:0]);
      #1 flit_in = '0;
   endtask

   // Monitor: every completed handshake must match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pop", 64'(payload), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [62:0] e;
            e = exp_q.pop_front();
            chk("head", 64'({src_z, src_y, src_x, context_id, tag, algtype, op, payload}),
                64'(e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int w, wsum;
      rst_n = 1'b0; flit_in = '0; flit_in2 = '0; out_ready = 1'b0;

      #23;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ready", 64'(flit_in_ready), 64'd1);
      chk("rst_rx", 64'(rx_count), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      chk("rst_payload", 64'(payload), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Two buffered flits, then asynchronous reset between edges
      send(mk(1,2,3, 0,0,0, 8'h00, 8'h01, 2'd0, 4'h1, 32'h1111_1111), 1'b1, w);
      send(mk(1,2,3, 0,0,0, 8'h00, 8'h02, 2'd0, 4'h2, 32'h2222_2222), 1'b1, w);
      @(negedge clk);
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      chk("pre_rst_rx", 64'(rx_count), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_ready", 64'(flit_in_ready), 64'd1);
      chk("async_rst_payload", 64'(payload), 64'd0);
      chk("async_rst_rx", 64'(rx_count), 64'd0);
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Single matching flit
      send(mk(1,2,3, 4,5,6, 8'h11, 8'h5A, 2'd2, 4'h3, 32'hDEAD_BEEF), 1'b1, w);
      @(negedge clk);
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_payload", 64'(payload), 64'hDEAD_BEEF);
      chk("single_op", 64'(op), 64'h3);
      chk("single_tag", 64'(tag), 64'h5A);
      chk("single_src", 64'({src_x, src_y, src_z}), 64'({3'd4, 3'd5, 3'd6}));
      chk("single_rx", 64'(rx_count), 64'd1);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      chk("single_popped", 64'(out_valid), 64'd0);
      chk("empty_fields_zero", 64'({tag, op, payload}), 64'd0);

      // Misrouted flit is consumed and counted
      send(mk(0,2,3, 4,5,6, 8'h22, 8'h33, 2'd1, 4'h4, 32'hBAD0_0001), 1'b0, w);
      @(negedge clk);
      chk("mis_drop", 64'(drop_count), 64'd1);
      chk("mis_rx", 64'(rx_count), 64'd1);
      chk("mis_valid", 64'(out_valid), 64'd0);
      chk("mis_waits", 64'(w), 64'd0);

      // Fill: five back-to-back with consumer stalled
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 5; i++)
               send(mk(1,2,3, 3'(i),1,2, 8'(i), 8'(8'h40 + i), 2'd3, 4'(i), 32'(100 + i)),
                    1'b1, w);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            chk("full_after4", 64'(flit_in_ready), 64'd0);
            repeat (2) @(posedge clk);
            #1;
            chk("full_held", 64'(flit_in_ready), 64'd0);
            chk("full_rx", 64'(rx_count), 64'd5);
            chk("full_valid", 64'(out_valid), 64'd1);
            out_ready = 1'b1;
            @(negedge clk);
            chk("full_pop_no_passthru", 64'(flit_in_ready), 64'd0);
            @(negedge clk);
            chk("after_pop_ready", 64'(flit_in_ready), 64'd1);
         end
      join
      repeat (6) @(posedge clk);
      #1;
      chk("fill_drained", 64'(out_valid), 64'd0);
      chk("fill_rx", 64'(rx_count), 64'd6);

      // Streaming with consumer always ready
      wsum = 0;
      for (int i = 0; i < 20; i++) begin
         send(mk(1,2,3, 7,0,1, 8'hC0, 8'(i), 2'd0, 4'hF, 32'(i)), 1'b1, w);
         wsum += w;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("stream_stalls", 64'(wsum), 64'd0);
      chk("stream_rx", 64'(rx_count), 64'd26);
      chk("stream_empty", 64'(out_valid), 64'd0);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("drop_unchanged", 64'(drop_count), 64'd1);

      // Saturating drop counter on the narrow-counter instance
      flit_in2 = {1'b1, mk(0,0,0, 1,1,1, 8'h00, 8'h00, 2'd0, 4'h0, 32'h0)};
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("sat_drop", 64'(drop_count2), (i + 1 > 15) ? 64'd15 : 64'(i + 1));
      end
      flit_in2 = '0;
      chk("sat_rx", 64'(rx_count2), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
